vector_mem_sequencer: RTL and testbench

Multi-cycle sequencer that executes vector load/store instructions in the Memory stage over the single 32-bit data-memory port. Splits a LANES-wide vector access into LANES word accesses, stalls the pipeline while it works, and assembles load results into one vector word for Writeback. Sits between the M-stage pipeline register (control: memdataM/memsrcM decode) and the data memory, alongside the hazard unit that consumes its stall output.

---
 rtl/vmem_pkg.sv | 13 +
 rtl/vmem_lane_buffer.sv | 29 ++
 rtl/vector_mem_sequencer.sv | 116 +++++++++++
 tb/tb_vector_mem_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and widths for the vector load/store sequencer.
// No logic: state encoding and data-word geometry only.
package vmem_pkg;
  localparam int WORD_W     = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DRAIN,
    DONE
  } vmemState_e;
endpackage

// File: rtl/vmem_lane_buffer.sv
// LANES x 32-bit assembly buffer: one indexed write per cycle, whole buffer readable flat.
// Write lands on the next rising edge; no backpressure, write enable is never refused.
module vmem_lane_buffer
  import vmem_pkg::*;
#(
  parameter int LANES = 4,
  localparam int IDX_W = $clog2(LANES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wrEn,
  input  logic [IDX_W-1:0]              wrIdx,
  input  logic [WORD_W-1:0]             wrData,
  output logic [LANES-1:0][WORD_W-1:0]  rdVec
);

  logic [LANES-1:0][WORD_W-1:0] lanes;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lanes <= '0;
    end else if (wrEn) begin
      lanes[wrIdx] <= wrData;
    end
  end

  assign rdVec = lanes;

endmodule

// File: rtl/vector_mem_sequencer.sv
// Splits a vector load/store into LANES word accesses on the data port and stalls the pipeline meanwhile.
// Store: LANES+2 cycles incl. accept; load: LANES+3 with result pulse in DONE; no backpressure from memory.
module vector_mem_sequencer
  import vmem_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vreqM,
  input  logic                      vwriteM,
  input  logic [31:0]               baseaddrM,
  input  logic [WORD_W*LANES-1:0]   vstoredataM,
  output logic [31:0]               mem_addr,
  output logic                      mem_we,
  output logic [WORD_W-1:0]         mem_wdata,
  input  logic [WORD_W-1:0]         mem_rdata,
  output logic                      stall,
  output logic [WORD_W*LANES-1:0]   vloaddataW,
  output logic                      vloadvalidW
);

  localparam int CNT_W = $clog2(LANES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  vmemState_e                   state, stateNext;
  logic [CNT_W-1:0]             laneCnt;
  logic [31:0]                  baseAddr;
  logic                         isStore;
  logic [LANES-1:0][WORD_W-1:0] storeVec;
  logic                         capVld;
  logic [CNT_W-1:0]             capIdx;
  logic [LANES-1:0][WORD_W-1:0] bufVec;
  logic [LANES-1:0][WORD_W-1:0] mergedVec;
  logic [LANES-1:0][WORD_W-1:0] loadVec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      laneCnt  <= '0;
      baseAddr <= '0;
      isStore  <= 1'b0;
      storeVec <= '0;
      capVld   <= 1'b0;
      capIdx   <= '0;
      loadVec  <= '0;
    end else begin
      state  <= stateNext;
      // Read data returns one cycle after its address, so capture trails issue by one.
      capVld <= (state == ACCESS) && !isStore;
      capIdx <= laneCnt;
      if (state == IDLE && vreqM) begin
        baseAddr <= {baseaddrM[31:2], 2'b00};
        isStore  <= vwriteM;
        storeVec <= vstoredataM;
        laneCnt  <= '0;
      end else if (state == ACCESS) begin
        laneCnt <= laneCnt + 1'b1;
      end
      if (state == DRAIN) begin
        loadVec <= mergedVec;
      end
    end
  end

  vmem_lane_buffer #(.LANES(LANES)) u_laneBuffer (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (capVld),
    .wrIdx  (capIdx),
    .wrData (mem_rdata),
    .rdVec  (bufVec)
  );

  // The last lane arrives in DRAIN; fold it in so the published vector is complete in DONE
  // while the previous result stays visible for the whole of a new load.
  always_comb begin
    mergedVec            = bufVec;
    mergedVec[LANES-1]   = mem_rdata;
  end

  assign vloaddataW = loadVec;

  always_comb begin
    stateNext   = state;
    stall       = 1'b0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wdata   = '0;
    vloadvalidW = 1'b0;
    case (state)
      IDLE: begin
        stall = vreqM & reset;
        if (vreqM) stateNext = ACCESS;
      end
      ACCESS: begin
        stall     = 1'b1;
        mem_addr  = baseAddr + (32'(laneCnt) << 2);
        mem_we    = isStore;
        mem_wdata = isStore ? storeVec[laneCnt] : '0;
        if (laneCnt == LAST_LANE) stateNext = isStore ? DONE : DRAIN;
      end
      DRAIN: begin
        stall     = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        // vreqM here still belongs to the departing instruction, so never accept.
        vloadvalidW = !isStore;
        stateNext   = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a behavioural synchronous-read data memory.
// Inputs are driven on the falling edge; outputs are checked 1ns later.
// Memory model never backpressures; reads return one cycle after the address.
module tb_vector_mem_sequencer;

    logic         clk;
    logic         reset;
    logic         vreqM;
    logic         vwriteM;
    logic [31:0]  baseaddrM;
    logic [127:0] vstoredataM;
    logic [31:0]  mem_addr;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         stall;
    logic [127:0] vloaddataW;
    logic         vloadvalidW;

    int checks = 0;
    int fails  = 0;

    logic [31:0] memModel [logic [31:0]];

    vector_mem_sequencer #(.LANES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .vreqM       (vreqM),
        .vwriteM     (vwriteM),
        .baseaddrM   (baseaddrM),
        .vstoredataM (vstoredataM),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .vloaddataW  (vloaddataW),
        .vloadvalidW (vloadvalidW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rdata <= memModel.exists(mem_addr) ? memModel[mem_addr] : 32'h0;
        if (mem_we) memModel[mem_addr] = mem_wdata;
    end

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; vreqM = 1'b1; vwriteM = 1'b1;
        baseaddrM = 32'h0000_0040; vstoredataM = {4{32'h5555_AAAA}};
        nextCycle(); nextCycle(); #1;
        checks++;
        if ({stall, mem_we, mem_addr, mem_wdata, vloadvalidW, vloaddataW} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: stall=%b we=%b addr=%h wdata=%h vld=%b data=%h, required all zero",
                     stall, mem_we, mem_addr, mem_wdata, vloadvalidW, vloaddataW);
        end
        vreqM = 1'b0; reset = 1'b1;
        nextCycle(); #1;
        checks++;
        if ({stall, mem_we} !== 2'b00) begin
            fails++;
            $display("FAIL reset_idle: stall=%b we=%b, required 0 0", stall, mem_we);
        end
    endtask

    task automatic test_store();
        logic [31:0] expData [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        vreqM = 1'b1; vwriteM = 1'b1; baseaddrM = 32'h100;
        vstoredataM = {32'h44, 32'h33, 32'h22, 32'h11};
        #1;
        checks++;
        if ({stall, mem_we} !== 2'b10) begin
            fails++;
            $display("FAIL store_accept: stall=%b we=%b, required 1 0", stall, mem_we);
        end
        for (int c = 1; c <= 4; c++) begin
            nextCycle(); #1;
            checks++;
            if ({stall, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100 + 32'(4 * (c - 1)), expData[c-1]}) begin
                fails++;
                $display("FAIL store_cycle%0d: stall=%b we=%b addr=%h wdata=%h, required 1 1 %h %h", c,
                         stall, mem_we, mem_addr, mem_wdata, 32'h100 + 32'(4 * (c - 1)), expData[c-1]);
            end
        end
        nextCycle(); #1;
        checks++;
        if ({stall, mem_we, vloadvalidW} !== 3'b000) begin
            fails++;
            $display("FAIL store_done: stall=%b we=%b vld=%b, required 0 0 0", stall, mem_we, vloadvalidW);
        end
        nextCycle(); vreqM = 1'b0; #1;
        checks++;
        if ({memModel[32'h100], memModel[32'h104], memModel[32'h108], memModel[32'h10C]} !==
            {32'h11, 32'h22, 32'h33, 32'h44}) begin
            fails++;
            $display("FAIL store_memory: %h %h %h %h, required 11 22 33 44", memModel[32'h100],
                     memModel[32'h104], memModel[32'h108], memModel[32'h10C]);
        end
    endtask

    task automatic test_load();
        memModel[32'h200] = 32'hA; memModel[32'h204] = 32'hB;
        memModel[32'h208] = 32'hC; memModel[32'h20C] = 32'hD;
        vreqM = 1'b1; vwriteM = 1'b0; baseaddrM = 32'h200;
        for (int c = 0; c <= 7; c++) begin
            if (c == 7) vreqM = 1'b0;
            #1;
            if (c >= 1 && c <= 4) begin
                checks++;
                if ({stall, mem_we, mem_addr, vloadvalidW} !== {1'b1, 1'b0, 32'h200 + 32'(4 * (c - 1)), 1'b0}) begin
                    fails++;
                    $display("FAIL load_cycle%0d: stall=%b we=%b addr=%h vld=%b, required 1 0 %h 0", c,
                             stall, mem_we, mem_addr, vloadvalidW, 32'h200 + 32'(4 * (c - 1)));
                end
            end else if (c == 5) begin
                checks++;
                if ({stall, mem_we, mem_addr, vloadvalidW} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
                    fails++;
                    $display("FAIL load_drain: stall=%b we=%b addr=%h vld=%b, required 1 0 0 0",
                             stall, mem_we, mem_addr, vloadvalidW);
                end
            end else if (c == 6) begin
                checks++;
                if ({stall, vloadvalidW, vloaddataW} !== {1'b0, 1'b1, 32'hD, 32'hC, 32'hB, 32'hA}) begin
                    fails++;
                    $display("FAIL load_done: stall=%b vld=%b data=%h, required 0 1 0000000d0000000c0000000b0000000a",
                             stall, vloadvalidW, vloaddataW);
                end
            end else if (c == 7) begin
                checks++;
                if ({vloadvalidW, vloaddataW} !== {1'b0, 32'hD, 32'hC, 32'hB, 32'hA}) begin
                    fails++;
                    $display("FAIL load_hold: vld=%b data=%h, required 0 0000000d0000000c0000000b0000000a",
                             vloadvalidW, vloaddataW);
                end
            end
            nextCycle();
        end
    endtask

    task automatic test_wrap();
        logic [31:0] expAddr [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        vreqM = 1'b1; vwriteM = 1'b1; baseaddrM = 32'hFFFF_FFFB;
        vstoredataM = {32'h7004, 32'h7003, 32'h7002, 32'h7001};
        for (int c = 1; c <= 4; c++) begin
            nextCycle(); #1;
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, expAddr[c-1], 32'h7000 + 32'(c)}) begin
                fails++;
                $display("FAIL wrap_cycle%0d: we=%b addr=%h wdata=%h, required 1 %h %h", c,
                         mem_we, mem_addr, mem_wdata, expAddr[c-1], 32'h7000 + 32'(c));
            end
        end
        nextCycle(); nextCycle(); vreqM = 1'b0; #1;
    endtask

    task automatic test_back_to_back();
        int reads = 0;
        int writes = 0;
        memModel[32'h300] = 32'h1; memModel[32'h304] = 32'h2;
        memModel[32'h308] = 32'h3; memModel[32'h30C] = 32'h4;
        vreqM = 1'b1; vwriteM = 1'b0; baseaddrM = 32'h300;
        for (int c = 0; c <= 13; c++) begin
            if (c == 7) begin
                vwriteM = 1'b1; baseaddrM = 32'h400;
                vstoredataM = {32'h8, 32'h7, 32'h6, 32'h5};
            end
            if (c == 13) vreqM = 1'b0;
            #1;
            if (mem_we) writes++;
            else if (mem_addr >= 32'h300 && mem_addr <= 32'h30C) reads++;
            if (c == 5) begin
                checks++;
                if (vloaddataW !== {32'hD, 32'hC, 32'hB, 32'hA}) begin
                    fails++;
                    $display("FAIL b2b_prev_hold: data=%h, required 0000000d0000000c0000000b0000000a", vloaddataW);
                end
            end else if (c == 6) begin
                checks++;
                if ({stall, vloadvalidW, vloaddataW} !== {1'b0, 1'b1, 32'h4, 32'h3, 32'h2, 32'h1}) begin
                    fails++;
                    $display("FAIL b2b_load_done: stall=%b vld=%b data=%h, required 0 1 00000004000000030000000200000001",
                             stall, vloadvalidW, vloaddataW);
                end
            end else if (c == 7) begin
                checks++;
                if ({stall, mem_we} !== 2'b10) begin
                    fails++;
                    $display("FAIL b2b_store_accept: stall=%b we=%b, required 1 0", stall, mem_we);
                end
            end else if (c == 12) begin
                checks++;
                if ({stall, mem_we} !== 2'b00) begin
                    fails++;
                    $display("FAIL b2b_store_done: stall=%b we=%b, required 0 0", stall, mem_we);
                end
            end
            nextCycle();
        end
        checks++;
        if (reads != 4 || writes != 4) begin
            fails++;
            $display("FAIL b2b_access_count: reads=%0d writes=%0d, required 4 4", reads, writes);
        end
        checks++;
        if ({memModel[32'h400], memModel[32'h404], memModel[32'h408], memModel[32'h40C]} !==
            {32'h5, 32'h6, 32'h7, 32'h8}) begin
            fails++;
            $display("FAIL b2b_store_memory: %h %h %h %h, required 5 6 7 8", memModel[32'h400],
                     memModel[32'h404], memModel[32'h408], memModel[32'h40C]);
        end
    endtask

    task automatic test_latch();
        logic [31:0] expData [4] = '{32'h6A, 32'h6B, 32'h6C, 32'h6D};
        vreqM = 1'b1; vwriteM = 1'b1; baseaddrM = 32'h600;
        vstoredataM = {32'h6D, 32'h6C, 32'h6B, 32'h6A};
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            if (c == 1) begin
                baseaddrM = 32'h700; vwriteM = 1'b0; vstoredataM = {4{32'hBAD0_BAD0}};
            end
            #1;
            checks++;
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h600 + 32'(4 * (c - 1)), expData[c-1]}) begin
                fails++;
                $display("FAIL latch_cycle%0d: we=%b addr=%h wdata=%h, required 1 %h %h", c,
                         mem_we, mem_addr, mem_wdata, 32'h600 + 32'(4 * (c - 1)), expData[c-1]);
            end
        end
        nextCycle(); nextCycle(); vreqM = 1'b0; #1;
        checks++;
        if (memModel.exists(32'h700)) begin
            fails++;
            $display("FAIL latch_no_stray_write: address 700 written=1, required 0");
        end
    endtask

    task automatic test_reset_mid();
        memModel[32'h500] = 32'hEEEE_EEEE; memModel[32'h504] = 32'hEEEE_EEEE;
        memModel[32'h508] = 32'hEEEE_EEEE; memModel[32'h50C] = 32'hEEEE_EEEE;
        vreqM = 1'b1; vwriteM = 1'b1; baseaddrM = 32'h500;
        vstoredataM = {32'h4, 32'h3, 32'h2, 32'h1};
        nextCycle(); nextCycle(); nextCycle();
        // Lanes 0 and 1 have been written; reset lands while lane 2 is on the port.
        reset = 1'b0; #1;
        checks++;
        if ({stall, mem_we, mem_addr, mem_wdata, vloadvalidW, vloaddataW} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: stall=%b we=%b addr=%h wdata=%h vld=%b data=%h, required all zero",
                     stall, mem_we, mem_addr, mem_wdata, vloadvalidW, vloaddataW);
        end
        nextCycle(); #1;
        checks++;
        if ({stall, mem_we} !== 2'b00) begin
            fails++;
            $display("FAIL midreset_held: stall=%b we=%b, required 0 0", stall, mem_we);
        end
        checks++;
        if ({memModel[32'h500], memModel[32'h504], memModel[32'h508], memModel[32'h50C]} !==
            {32'h1, 32'h2, 32'hEEEE_EEEE, 32'hEEEE_EEEE}) begin
            fails++;
            $display("FAIL midreset_memory: %h %h %h %h, required 1 2 eeeeeeee eeeeeeee", memModel[32'h500],
                     memModel[32'h504], memModel[32'h508], memModel[32'h50C]);
        end
        vreqM = 1'b0; reset = 1'b1;
        nextCycle();
        vreqM = 1'b1; vwriteM = 1'b0; baseaddrM = 32'h200;
        for (int c = 0; c <= 6; c++) begin
            #1;
            if (c == 5) begin
                checks++;
                if ({stall, vloadvalidW} !== 2'b10) begin
                    fails++;
                    $display("FAIL postreset_drain: stall=%b vld=%b, required 1 0", stall, vloadvalidW);
                end
            end else if (c == 6) begin
                checks++;
                if ({stall, vloadvalidW, vloaddataW} !== {1'b0, 1'b1, 32'hD, 32'hC, 32'hB, 32'hA}) begin
                    fails++;
                    $display("FAIL postreset_load: stall=%b vld=%b data=%h, required 0 1 0000000d0000000c0000000b0000000a",
                             stall, vloadvalidW, vloaddataW);
                end
            end
            nextCycle();
        end
        vreqM = 1'b0;
    endtask

    initial begin
        vreqM = 1'b0; vwriteM = 1'b0; baseaddrM = '0; vstoredataM = '0; reset = 1'b0;
        test_reset();
        test_store();
        test_load();
        test_wrap();
        test_back_to_back();
        test_latch();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
